// File: rtl/riscv_alu_unit_pkg.sv
// Shared definitions for the RISC-V ALU: data width, op-code constants,
// the operation enum used by the decoder, and a small op classification helper.
package riscv_alu_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b00001;
  localparam logic [4:0] OP_SLL    = 5'b00010;
  localparam logic [4:0] OP_SLT    = 5'b00011;
  localparam logic [4:0] OP_SLTU   = 5'b00100;
  localparam logic [4:0] OP_XOR    = 5'b00101;
  localparam logic [4:0] OP_SRL    = 5'b00110;
  localparam logic [4:0] OP_SRA    = 5'b00111;
  localparam logic [4:0] OP_OR     = 5'b01000;
  localparam logic [4:0] OP_AND    = 5'b01001;
  localparam logic [4:0] OP_PASS   = 5'b01010;
  localparam logic [4:0] OP_MUL    = 5'b01011;
  localparam logic [4:0] OP_MULH   = 5'b01100;
  localparam logic [4:0] OP_MULHSU = 5'b01101;
  localparam logic [4:0] OP_MULHU  = 5'b01110;

  typedef enum logic [4:0] {
    ALU_ADD    = OP_ADD,
    ALU_SUB    = OP_SUB,
    ALU_SLL    = OP_SLL,
    ALU_SLT    = OP_SLT,
    ALU_SLTU   = OP_SLTU,
    ALU_XOR    = OP_XOR,
    ALU_SRL    = OP_SRL,
    ALU_SRA    = OP_SRA,
    ALU_OR     = OP_OR,
    ALU_AND    = OP_AND,
    ALU_PASS   = OP_PASS,
    ALU_MUL    = OP_MUL,
    ALU_MULH   = OP_MULH,
    ALU_MULHSU = OP_MULHSU,
    ALU_MULHU  = OP_MULHU
  } alu_op_e;

  // True for the four RV32M multiply codes.
  function automatic logic is_mul_op(input logic [4:0] code);
    return (code == OP_MUL) || (code == OP_MULH) ||
           (code == OP_MULHSU) || (code == OP_MULHU);
  endfunction

endpackage

// File: rtl/riscv_alu_unit_branch_cmp.sv
// Combinational branch comparator: equality plus signed/unsigned less-than.
module branch_cmp
  import riscv_alu_unit_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            br_un_i,
  output logic            eq_o,
  output logic            lt_o
);

  // Less-than switches between two's-complement and magnitude ordering.
  always_comb begin
    eq_o = (a_i == b_i);
    lt_o = 1'b0;
    if (br_un_i) begin
      lt_o = (a_i < b_i);
    end else begin
      lt_o = ($signed(a_i) < $signed(b_i));
    end
  end

endmodule

// File: rtl/riscv_alu_unit.sv
// RISC-V integer ALU with optional RV32M multiply, one-cycle registered
// results, and branch compare flags computed alongside every valid op.
module riscv_alu_unit
  import riscv_alu_unit_pkg::*;
#(
  parameter int M_EXT = 1
) (
  input  logic            clock,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [4:0]      alu_ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] imm,
  input  logic            bsel,
  input  logic            br_un,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_out,
  output logic            zero,
  output logic            br_eq,
  output logic            br_lt,
  output logic            br_ge,
  output logic            illegal
);

  alu_op_e         aluOp;
  logic [XLEN-1:0] op2;
  logic [4:0]      shamt;
  logic            mulASigned;
  logic            mulBSigned;
  logic [63:0]     mulAExt;
  logic [63:0]     mulBExt;
  logic [63:0]     mulProd;
  logic            cmpEq;
  logic            cmpLt;

  logic [XLEN-1:0] result_d;
  logic            illegal_d;

  logic            outValid_q;
  logic [XLEN-1:0] aluOut_q;
  logic            zero_q;
  logic            brEq_q;
  logic            brLt_q;
  logic            brGe_q;
  logic            illegal_q;

  assign aluOp = alu_op_e'(alu_ctrl);
  assign op2   = bsel ? imm : b;
  assign shamt = op2[4:0];

  // A single 64-bit multiplier serves all four multiply flavours; the
  // operands are sign- or zero-extended depending on the op so the upper
  // half of the truncated product is the correct high word in every case.
  assign mulASigned = (aluOp == ALU_MULH) || (aluOp == ALU_MULHSU);
  assign mulBSigned = (aluOp == ALU_MULH);
  assign mulAExt    = {{32{mulASigned & a[31]}}, a};
  assign mulBExt    = {{32{mulBSigned & op2[31]}}, op2};
  assign mulProd    = mulAExt * mulBExt;

  branch_cmp u_branch_cmp (
    .a_i     (a),
    .b_i     (b),
    .br_un_i (br_un),
    .eq_o    (cmpEq),
    .lt_o    (cmpLt)
  );

  // Decode the op and select the result; unknown codes, and multiplies
  // when the M extension is disabled, yield zero and flag illegal.
  always_comb begin
    result_d  = '0;
    illegal_d = 1'b0;
    case (aluOp)
      ALU_ADD:  result_d = a + op2;
      ALU_SUB:  result_d = a - op2;
      ALU_SLL:  result_d = a << shamt;
      ALU_SLT:  result_d = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(op2))};
      ALU_SLTU: result_d = {{(XLEN-1){1'b0}}, (a < op2)};
      ALU_XOR:  result_d = a ^ op2;
      ALU_SRL:  result_d = a >> shamt;
      ALU_SRA:  result_d = $unsigned($signed(a) >>> shamt);
      ALU_OR:   result_d = a | op2;
      ALU_AND:  result_d = a & op2;
      ALU_PASS: result_d = op2;
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: begin
        if (M_EXT != 0) begin
          result_d = (aluOp == ALU_MUL) ? mulProd[31:0] : mulProd[63:32];
        end else begin
          illegal_d = 1'b1;
        end
      end
      default:  illegal_d = 1'b1;
    endcase
  end

  // Output registers: reset clears everything, a valid op loads a fresh
  // result, and an idle cycle only drops out_valid while holding the rest.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      aluOut_q   <= '0;
      zero_q     <= 1'b0;
      brEq_q     <= 1'b0;
      brLt_q     <= 1'b0;
      brGe_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      outValid_q <= in_valid;
      if (in_valid) begin
        aluOut_q  <= result_d;
        zero_q    <= (result_d == '0);
        brEq_q    <= cmpEq;
        brLt_q    <= cmpLt;
        brGe_q    <= ~cmpLt;
        illegal_q <= illegal_d;
      end
    end
  end

  assign out_valid = outValid_q;
  assign alu_out   = aluOut_q;
  assign zero      = zero_q;
  assign br_eq     = brEq_q;
  assign br_lt     = brLt_q;
  assign br_ge     = brGe_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_riscv_alu_unit.sv
// Self-checking bench for riscv_alu_unit: two instances (M extension on and
// off) share one stimulus stream and are compared every cycle against an
// arithmetic reference model, with directed cases pinning known answers.
module tb_riscv_alu_unit;
  import riscv_alu_unit_pkg::*;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [4:0]  alu_ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] imm;
  logic        bsel;
  logic        br_un;

  logic        outValid [2];
  logic [31:0] aluOut   [2];
  logic        zeroFlag [2];
  logic        brEq     [2];
  logic        brLt     [2];
  logic        brGe     [2];
  logic        illegal  [2];

  logic        mValid   [2];
  logic [31:0] mOut     [2];
  logic        mZero    [2];
  logic        mEq      [2];
  logic        mLt      [2];
  logic        mGe      [2];
  logic        mIll     [2];
  bit          modelKnown = 1'b0;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clock = ~clock;

  riscv_alu_unit #(.M_EXT(0)) dut0 (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .alu_ctrl(alu_ctrl),
    .a(a), .b(b), .imm(imm), .bsel(bsel), .br_un(br_un),
    .out_valid(outValid[0]), .alu_out(aluOut[0]), .zero(zeroFlag[0]),
    .br_eq(brEq[0]), .br_lt(brLt[0]), .br_ge(brGe[0]), .illegal(illegal[0])
  );

  riscv_alu_unit #(.M_EXT(1)) dut1 (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .alu_ctrl(alu_ctrl),
    .a(a), .b(b), .imm(imm), .bsel(bsel), .br_un(br_un),
    .out_valid(outValid[1]), .alu_out(aluOut[1]), .zero(zeroFlag[1]),
    .br_eq(brEq[1]), .br_lt(brLt[1]), .br_ge(brGe[1]), .illegal(illegal[1])
  );

  // Reference ALU written as plain integer arithmetic on 64-bit values.
  function automatic void refAlu(input logic [4:0] ctrl, input logic [31:0] x,
                                 input logic [31:0] y, input bit mext,
                                 output logic [31:0] res, output logic ill);
    longint      sx;
    longint      sy;
    longint      sp;
    logic [63:0] up;
    int          sh;
    sx  = $signed(x);
    sy  = $signed(y);
    sh  = int'(y % 32);
    up  = {32'b0, x} * {32'b0, y};
    res = 32'h0;
    ill = 1'b0;
    case (ctrl)
      OP_ADD:  res = x + y;
      OP_SUB:  res = x - y;
      OP_SLL:  begin up = {32'b0, x} * (64'd1 << sh); res = up[31:0]; end
      OP_SLT:  res = (sx < sy) ? 32'd1 : 32'd0;
      OP_SLTU: res = ({32'b0, x} < {32'b0, y}) ? 32'd1 : 32'd0;
      OP_XOR:  res = x ^ y;
      OP_SRL:  res = x / (32'd1 << sh);
      OP_SRA:  res = (x >> sh) | (x[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      OP_OR:   res = x | y;
      OP_AND:  res = x & y;
      OP_PASS: res = y;
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: begin
        if (!mext) begin
          ill = 1'b1;
        end else if (ctrl == OP_MUL) begin
          res = up[31:0];
        end else if (ctrl == OP_MULHU) begin
          res = up[63:32];
        end else if (ctrl == OP_MULH) begin
          sp  = sx * sy;
          res = 32'(sp >>> 32);
        end else begin
          sp  = sx * longint'({32'b0, y});
          res = 32'(sp >>> 32);
        end
      end
      default: ill = 1'b1;
    endcase
  endfunction

  // Model state advances on each rising edge from the stable inputs.
  always @(posedge clock) begin
    logic [31:0] r;
    logic        il;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mValid[i] = 1'b0; mOut[i] = 32'h0; mZero[i] = 1'b0;
        mEq[i] = 1'b0; mLt[i] = 1'b0; mGe[i] = 1'b0; mIll[i] = 1'b0;
      end else begin
        mValid[i] = in_valid;
        if (in_valid) begin
          refAlu(alu_ctrl, a, bsel ? imm : b, (i == 1), r, il);
          mOut[i]  = r;
          mIll[i]  = il;
          mZero[i] = (r == 32'h0);
          mEq[i]   = (a == b);
          mLt[i]   = br_un ? ({1'b0, a} < {1'b0, b})
                           : (longint'($signed(a)) < longint'($signed(b)));
          mGe[i]   = !mLt[i];
        end
      end
    end
    if (!rst_n) modelKnown = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Compare every output of both instances against the model each cycle.
  always @(posedge clock) begin
    #1;
    if (modelKnown) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("m%0d_out_valid", i), {31'b0, outValid[i]}, {31'b0, mValid[i]});
        checkOutput($sformatf("m%0d_alu_out", i), aluOut[i], mOut[i]);
        checkOutput($sformatf("m%0d_zero", i), {31'b0, zeroFlag[i]}, {31'b0, mZero[i]});
        checkOutput($sformatf("m%0d_br_eq", i), {31'b0, brEq[i]}, {31'b0, mEq[i]});
        checkOutput($sformatf("m%0d_br_lt", i), {31'b0, brLt[i]}, {31'b0, mLt[i]});
        checkOutput($sformatf("m%0d_br_ge", i), {31'b0, brGe[i]}, {31'b0, mGe[i]});
        checkOutput($sformatf("m%0d_illegal", i), {31'b0, illegal[i]}, {31'b0, mIll[i]});
      end
    end
  end

  task automatic applyStimulus(input logic [4:0] ctrl, input logic [31:0] x,
                               input logic [31:0] y, input logic [31:0] im,
                               input logic bs, input logic bu, input logic v,
                               input logic rst);
    @(negedge clock);
    alu_ctrl = ctrl; a = x; b = y; imm = im;
    bsel = bs; br_un = bu; in_valid = v; rst_n = rst;
  endtask

  task automatic waitResult();
    @(posedge clock);
    #2;
  endtask

  function automatic logic [31:0] randWord();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; alu_ctrl = OP_ADD;
    a = 32'h1234; b = 32'h1; imm = 32'h0; bsel = 1'b0; br_un = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    checkOutput("reset_out_valid", {31'b0, outValid[1]}, 32'h0);
    checkOutput("reset_alu_out", aluOut[1], 32'h0);
    checkOutput("reset_zero", {31'b0, zeroFlag[1]}, 32'h0);

    applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    waitResult();
    checkOutput("add_wrap_valid", {31'b0, outValid[1]}, 32'h1);
    checkOutput("add_wrap_out", aluOut[1], 32'h0);
    checkOutput("add_wrap_zero", {31'b0, zeroFlag[1]}, 32'h1);
    checkOutput("signed_br_lt", {31'b0, brLt[1]}, 32'h1);
    checkOutput("signed_br_ge", {31'b0, brGe[1]}, 32'h0);
    checkOutput("signed_br_eq", {31'b0, brEq[1]}, 32'h0);

    applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    waitResult();
    checkOutput("unsigned_br_lt", {31'b0, brLt[1]}, 32'h0);
    checkOutput("unsigned_br_ge", {31'b0, brGe[1]}, 32'h1);

    applyStimulus(OP_SRA, 32'h8000_0000, 32'h0, 32'h0000_0024, 1'b1, 1'b0, 1'b1, 1'b1);
    waitResult();
    checkOutput("sra_imm", aluOut[1], 32'hF800_0000);
    checkOutput("br_ignores_imm", {31'b0, brEq[1]}, 32'h0);

    applyStimulus(OP_MULH, 32'hFFFF_FFFF, 32'h2, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    waitResult();
    checkOutput("mulh", aluOut[1], 32'hFFFF_FFFF);
    applyStimulus(OP_MULHU, 32'hFFFF_FFFF, 32'h2, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    waitResult();
    checkOutput("mulhu", aluOut[1], 32'h0000_0001);
    applyStimulus(OP_MULHSU, 32'hFFFF_FFFF, 32'h2, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    waitResult();
    checkOutput("mulhsu", aluOut[1], 32'hFFFF_FFFF);
    applyStimulus(OP_MUL, 32'hFFFF_FFFF, 32'h2, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    waitResult();
    checkOutput("mul", aluOut[1], 32'hFFFF_FFFE);
    checkOutput("mul_noext_illegal", {31'b0, illegal[0]}, 32'h1);
    checkOutput("mul_noext_out", aluOut[0], 32'h0);

    applyStimulus(5'b11111, 32'h5, 32'h3, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    waitResult();
    checkOutput("bad_op_out", aluOut[1], 32'h0);
    checkOutput("bad_op_illegal", {31'b0, illegal[1]}, 32'h1);

    applyStimulus(OP_ADD, 32'h5, 32'h7, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    waitResult();
    checkOutput("rst_over_valid", {31'b0, outValid[1]}, 32'h0);
    checkOutput("rst_alu_out", aluOut[1], 32'h0);
    checkOutput("rst_illegal", {31'b0, illegal[1]}, 32'h0);

    applyStimulus(OP_ADD, 32'h5, 32'h7, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    waitResult();
    checkOutput("first_after_rst", aluOut[1], 32'h0000_000C);
    applyStimulus(OP_SUB, 32'h9, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    waitResult();
    checkOutput("stall_valid", {31'b0, outValid[1]}, 32'h0);
    checkOutput("stall_hold", aluOut[1], 32'h0000_000C);

    for (int n = 0; n < 3000; n++) begin
      logic [4:0] ctrl;
      ctrl = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(15, 31))
                                         : 5'($urandom_range(0, 14));
      applyStimulus(ctrl, randWord(), randWord(), randWord(),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 4) != 0), ($urandom_range(0, 49) != 0));
    end

    applyStimulus(OP_ADD, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clock);
    #3;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
